vga_scan_ctrl: RTL and testbench
================================

// Module: vga_scan_ctrl
// PURPOSE
//  Raster timing controller for the VGA video path. Generates pixel-rate scan
//  counters (x, y) that address the video generator / logo ROM, then delays
//  hsync, vsync and display-enable by the generator's read latency. Colour
//  therefore reaches the DAC pins aligned with its sync, and is forced black
//  outside the active area. Sits between the clock tree and the top-level pins.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels); H_TOTAL = sum = 800, must be <= 1024
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines); V_TOTAL = sum = 525, must be <= 1024
//  SYNC_POL  0    asserted level of hsync/vsync (0 = active-low)
//  PIPE_LAT  1    pixel ticks from x/y valid to r/g/b valid at the generator (>= 1)
//  CLK_DIV   1    clk cycles per pixel tick (>= 1)
// PORTS
//  clk        in   1   system clock
//  nreset     in   1   asynchronous active-low reset
//  en         in   1   run enable; low freezes all state
//  x          out  10  current horizontal scan count, to the generator
//  y          out  10  current vertical scan count, to the generator
//  pixTick    out  1   one-clk pulse per pixel
//  lineStart  out  1   pixTick-qualified pulse when x==0
//  frameStart out  1   pixTick-qualified pulse when x==0 && y==0
//  rIn,gIn,bIn in  4   colour returned by the generator (PIPE_LAT ticks behind x/y)
//  hsync      out  1   registered horizontal sync, aligned with rOut
//  vsync      out  1   registered vertical sync, aligned with rOut
//  de         out  1   registered display enable, aligned with rOut
//  rOut,gOut,bOut out 4 colour to pins: {rIn,gIn,bIn} when de, else 0 (combinational AND)
// BEHAVIOUR
//  - Reset, async on nreset low: divCnt=0, hCnt=0, vCnt=0, all delay stages =
//    {hs=~SYNC_POL, vs=~SYNC_POL, de=0}. Outputs: x=0, y=0, pixTick=0,
//    lineStart=0, frameStart=0, de=0, hsync=vsync=~SYNC_POL, rOut/gOut/bOut=0.
//  - Divider: divCnt counts 0..CLK_DIV-1 while en=1.
//    pixTick = en && divCnt==CLK_DIV-1. With CLK_DIV=1, pixTick==en.
//  - Scan: on pixTick, hCnt increments; at hCnt==H_TOTAL-1 it wraps to 0 and vCnt
//    increments. At vCnt==V_TOTAL-1 with hCnt wrapping, vCnt wraps to 0.
//    x=hCnt, y=vCnt, driven directly from registers.
//  - Stage-0 decode from hCnt/vCnt:
//      active = hCnt<H_ACTIVE && vCnt<V_ACTIVE
//      hsAct  = H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC
//      vsAct  = V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC
//  - Delay line: PIPE_LAT register stages shift only on pixTick.
//    The last stage drives de, hsync (= hsAct ? SYNC_POL : ~SYNC_POL) and vsync.
//    Net effect: de/hsync/vsync lag x/y by exactly PIPE_LAT ticks.
//  - lineStart/frameStart: asserted in the same clk as pixTick while the counters
//    hold x==0 (and y==0). They are not delayed.
//  - en low: pixTick=0 and divCnt, counters and delay stages hold; outputs are static.
//    en returning high resumes from the frozen position with no skipped pixel.
//  - Reset mid-frame returns to (0,0) immediately. The first post-reset frameStart
//    pulses on the first pixTick.
//  - Counters are 10-bit unsigned. Comparisons use full-width constants; no
//    signed arithmetic.
// TESTING
//  1. Reset, en=1, CLK_DIV=1: x runs 0..799 then 0 with y+1. y wraps 524->0.
//     frameStart pulses every 420000 clk.
//  2. PIPE_LAT=1: hsync goes low 1 tick after x=656 and stays low 96 ticks.
//     de is high 640 ticks per line, starting 1 tick after x=0, on lines 0..479 only.
//  3. vsync is low for exactly 1600 ticks, starting 1 tick after (x=0,y=490).
//     hsync keeps toggling during vsync.
//  4. rIn=gIn=bIn=4'hF held constant: rOut=F only while de=1. It reads 0 in
//     porches, sync and lines 480..524.
//  5. CLK_DIV=2: pixTick every 2nd clk, x advances every 2 clk.
//     Frame = 840000 clk; sync widths double in clk.
//  6. en low at x=300 for 10 clk: x, y, hsync, de frozen, no pulses.
//     Then nreset low mid-line: x=0, y=0, de=0, hsync=vsync=1 without waiting for clk.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_ctrl
// Desc     : VGA raster counters plus sync/display-enable delayed to match the
//            pixel generator read latency; colour blanked outside active area.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned PIPE_LAT = 1,
  parameter int unsigned CLK_DIV  = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixTick,
  output logic       lineStart,
  output logic       frameStart,
  input  logic [3:0] rIn,
  input  logic [3:0] gIn,
  input  logic [3:0] bIn,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [3:0] rOut,
  output logic [3:0] gOut,
  output logic [3:0] bOut
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  // One extra bit so region bounds equal to 1024 still compare correctly.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic                div_last;
  logic                pix_tick;
  logic [9:0]          h_q, h_d, v_q, v_d;
  logic                act0, hs_on, vs_on;
  logic [PIPE_LAT-1:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;

  generate
    if (CLK_DIV > 1) begin : g_div_cnt
      localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
      logic [DIV_W-1:0] div_q, div_d;

      always_comb begin
        div_d = div_q;
        if (en) begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
      end

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) div_q <= '0;
        else         div_q <= div_d;
      end

      assign div_last = (div_q == DIV_LAST);
    end else begin : g_div_none
      assign div_last = 1'b1;
    end
  endgenerate

  assign pix_tick = en & nreset & div_last;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  assign act0  = ({1'b0, h_q} < H_ACT_END) && ({1'b0, v_q} < V_ACT_END);
  assign hs_on = ({1'b0, h_q} >= HS_BEG) && ({1'b0, h_q} < HS_END);
  assign vs_on = ({1'b0, v_q} >= VS_BEG) && ({1'b0, v_q} < VS_END);

  // Stages hold sync at pin polarity, so the last stage drives the pins directly.
  always_comb begin
    hs_d = hs_q;
    vs_d = vs_q;
    de_d = de_q;
    if (pix_tick) begin
      hs_d[0] = hs_on ? SYNC_POL : ~SYNC_POL;
      vs_d[0] = vs_on ? SYNC_POL : ~SYNC_POL;
      de_d[0] = act0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        hs_d[i] = hs_q[i-1];
        vs_d[i] = vs_q[i-1];
        de_d[i] = de_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= {PIPE_LAT{~SYNC_POL}};
      vs_q <= {PIPE_LAT{~SYNC_POL}};
      de_q <= '0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
    end
  end

  assign x          = h_q;
  assign y          = v_q;
  assign pixTick    = pix_tick;
  assign lineStart  = pix_tick && (h_q == 10'd0);
  assign frameStart = pix_tick && (h_q == 10'd0) && (v_q == 10'd0);
  assign hsync      = hs_q[PIPE_LAT-1];
  assign vsync      = vs_q[PIPE_LAT-1];
  assign de         = de_q[PIPE_LAT-1];
  assign rOut       = rIn & {4{de}};
  assign gOut       = gIn & {4{de}};
  assign bOut       = bIn & {4{de}};

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// Testbench for vga_scan_ctrl: a standard-timing instance plus a tiny-frame
// instance with clock division, deeper latency and active-high sync.
`timescale 1ns/1ps
module tb_vga_scan_ctrl;

  localparam int B_HA = 8, B_HFP = 2, B_HS = 3, B_HBP = 2;
  localparam int B_VA = 4, B_VFP = 1, B_VS = 2, B_VBP = 1;
  localparam int B_DIV = 2, B_LAT = 2;
  localparam logic B_POL = 1'b1;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst_a, en_a, nrst_b, en_b;
  logic [3:0] r_in, g_in, b_in;

  logic [9:0] a_xo, a_yo, b_xo, b_yo;
  logic a_pix, a_ls, a_fs, a_hs, a_vs, a_de;
  logic b_pix, b_ls, b_fs, b_hs, b_vs, b_de;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

  vga_scan_ctrl dut_a (
    .clk(clk), .nreset(nrst_a), .en(en_a), .x(a_xo), .y(a_yo),
    .pixTick(a_pix), .lineStart(a_ls), .frameStart(a_fs),
    .rIn(r_in), .gIn(g_in), .bIn(b_in),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .rOut(a_r), .gOut(a_g), .bOut(a_b)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .SYNC_POL(B_POL), .PIPE_LAT(B_LAT), .CLK_DIV(B_DIV)
  ) dut_b (
    .clk(clk), .nreset(nrst_b), .en(en_b), .x(b_xo), .y(b_yo),
    .pixTick(b_pix), .lineStart(b_ls), .frameStart(b_fs),
    .rIn(r_in), .gIn(g_in), .bIn(b_in),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .rOut(b_r), .gOut(b_g), .bOut(b_b)
  );

  logic [37:0] got_a, got_b;
  assign got_a = {a_xo, a_yo, a_pix, a_ls, a_fs, a_hs, a_vs, a_de, a_r, a_g, a_b};
  assign got_b = {b_xo, b_yo, b_pix, b_ls, b_fs, b_hs, b_vs, b_de, b_r, b_g, b_b};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state; scoreboards carry {hs,vs,de} through the latency.
  int         a_x, a_y, b_x, b_y, b_div;
  logic [2:0] qa[$];
  logic [2:0] qb[$];
  logic [2:0] a_exp, b_exp;

  function automatic logic [2:0] sync_of(int px, int py, int ha, int hfp, int hs,
                                         int va, int vfp, int vs, logic pol);
    logic h_on, v_on, act;
    h_on = (px >= ha + hfp) && (px < ha + hfp + hs);
    v_on = (py >= va + vfp) && (py < va + vfp + vs);
    act  = (px < ha) && (py < va);
    return {h_on ? pol : ~pol, v_on ? pol : ~pol, act};
  endfunction

  function automatic logic [37:0] exp_a();
    logic pt;
    pt = nrst_a && en_a;
    return {10'(a_x), 10'(a_y), pt, pt && a_x == 0, pt && a_x == 0 && a_y == 0,
            a_exp, a_exp[0] ? {r_in, g_in, b_in} : 12'h000};
  endfunction

  function automatic logic [37:0] exp_b();
    logic pt;
    pt = nrst_b && en_b && (b_div == B_DIV - 1);
    return {10'(b_x), 10'(b_y), pt, pt && b_x == 0, pt && b_x == 0 && b_y == 0,
            b_exp, b_exp[0] ? {r_in, g_in, b_in} : 12'h000};
  endfunction

  task automatic reset_model_a();
    a_x = 0; a_y = 0; qa.delete(); a_exp = 3'b110;
  endtask

  task automatic reset_model_b();
    b_x = 0; b_y = 0; b_div = 0; qb.delete();
    b_exp = {~B_POL, ~B_POL, 1'b0};
    for (int i = 0; i < B_LAT - 1; i++) qb.push_back({~B_POL, ~B_POL, 1'b0});
  endtask

  // Advance one clk: push expectations for positions ticked now, pop after the edge.
  task automatic cycle();
    logic ta, tb, runb;
    ta   = nrst_a && en_a;
    runb = nrst_b && en_b;
    tb   = runb && (b_div == B_DIV - 1);
    if (ta) qa.push_back(sync_of(a_x, a_y, 640, 16, 96, 480, 10, 2, 1'b0));
    if (tb) qb.push_back(sync_of(b_x, b_y, B_HA, B_HFP, B_HS, B_VA, B_VFP, B_VS, B_POL));
    @(posedge clk);
    #1;
    if (ta) begin
      a_exp = qa.pop_front();
      if (a_x == 799) begin a_x = 0; a_y = (a_y == 524) ? 0 : a_y + 1; end
      else a_x++;
    end
    if (runb) b_div = (b_div == B_DIV - 1) ? 0 : b_div + 1;
    if (tb) begin
      b_exp = qb.pop_front();
      if (b_x == B_HT - 1) begin b_x = 0; b_y = (b_y == B_VT - 1) ? 0 : b_y + 1; end
      else b_x++;
    end
  endtask

  task automatic test_reset();
    logic [37:0] e;
    nrst_a = 1'b0; nrst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    r_in = 4'hF; g_in = 4'hA; b_in = 4'h5;
    reset_model_a(); reset_model_b();
    repeat (3) cycle();
    e = exp_a();
    n_checks++; if (got_a !== e) $display("FAIL reset_a_vector got=%h exp=%h", got_a, e); else n_pass++;
    e = exp_b();
    n_checks++; if (got_b !== e) $display("FAIL reset_b_vector got=%h exp=%h", got_b, e); else n_pass++;
    n_checks++; if (a_hs !== 1'b1 || a_vs !== 1'b1) $display("FAIL reset_a_sync got=%b%b exp=11", a_hs, a_vs); else n_pass++;
    n_checks++; if (b_hs !== 1'b0 || b_vs !== 1'b0) $display("FAIL reset_b_sync got=%b%b exp=00", b_hs, b_vs); else n_pass++;
    n_checks++; if (a_r !== 4'h0 || a_de !== 1'b0) $display("FAIL reset_a_blank rOut=%h de=%b exp=0,0", a_r, a_de); else n_pass++;
  endtask

  task automatic test_line_timing();
    logic [37:0] e;
    int   hs_fall_x, hs_low, de_cnt, de_first_x;
    logic hs_p, in_low;
    hs_fall_x = -1; hs_low = 0; de_cnt = 0; de_first_x = -1; hs_p = 1'b1; in_low = 1'b0;
    nrst_a = 1'b1; en_a = 1'b1;
    #1;
    n_checks++; if (a_fs !== 1'b1 || a_xo !== 10'd0) $display("FAIL first_frame_start fs=%b x=%0d exp=1,0", a_fs, a_xo); else n_pass++;
    for (int i = 0; i < 2400; i++) begin
      cycle();
      e = exp_a();
      n_checks++;
      if (got_a !== e) $display("FAIL line_a_vector i=%0d got=%h exp=%h", i, got_a, e); else n_pass++;
      if (hs_p && !a_hs && hs_fall_x < 0) begin hs_fall_x = a_xo; in_low = 1'b1; end
      if (in_low) begin if (!a_hs) hs_low++; else in_low = 1'b0; end
      if (i < 800 && a_de) de_cnt++;
      if (de_first_x < 0 && a_de) de_first_x = a_xo;
      hs_p = a_hs;
    end
    n_checks++; if (hs_fall_x != 657) $display("FAIL hsync_start x=%0d exp=657", hs_fall_x); else n_pass++;
    n_checks++; if (hs_low != 96) $display("FAIL hsync_width got=%0d exp=96", hs_low); else n_pass++;
    n_checks++; if (de_cnt != 640) $display("FAIL de_per_line got=%0d exp=640", de_cnt); else n_pass++;
    n_checks++; if (de_first_x != 1) $display("FAIL de_start x=%0d exp=1", de_first_x); else n_pass++;
  endtask

  task automatic test_freeze_and_reset();
    logic [37:0] e;
    for (int i = 0; i < 900 && a_x != 300; i++) begin
      cycle();
      e = exp_a();
      n_checks++;
      if (got_a !== e) $display("FAIL seek_a_vector got=%h exp=%h", got_a, e); else n_pass++;
    end
    n_checks++; if (a_xo !== 10'd300) $display("FAIL seek_x300 got=%0d exp=300", a_xo); else n_pass++;
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      e = exp_a();
      n_checks++;
      if (got_a !== e || a_xo !== 10'd300 || a_pix !== 1'b0)
        $display("FAIL freeze_a i=%0d got=%h exp=%h", i, got_a, e);
      else n_pass++;
    end
    en_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      e = exp_a();
      n_checks++;
      if (got_a !== e) $display("FAIL resume_a i=%0d got=%h exp=%h", i, got_a, e); else n_pass++;
    end
    #3;
    nrst_a = 1'b0;
    #1;
    n_checks++;
    if ({a_xo, a_yo, a_de, a_hs, a_vs} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1})
      $display("FAIL async_reset x=%0d y=%0d de=%b hs=%b vs=%b exp=0,0,0,1,1", a_xo, a_yo, a_de, a_hs, a_vs);
    else n_pass++;
    reset_model_a();
    en_a = 1'b0;
  endtask

  task automatic test_small_frame_div2();
    logic [37:0] e;
    int   fs_cnt, fs_last, vs_cnt, hs_rise_in_vs, pix_cnt;
    logic hs_p;
    fs_cnt = 0; fs_last = -1; vs_cnt = 0; hs_rise_in_vs = 0; pix_cnt = 0; hs_p = ~B_POL;
    r_in = 4'h3; g_in = 4'hC; b_in = 4'h9;
    reset_model_b();
    nrst_b = 1'b1; en_b = 1'b1;
    for (int i = 0; i < 720; i++) begin
      cycle();
      e = exp_b();
      n_checks++;
      if (got_b !== e) $display("FAIL frame_b_vector i=%0d got=%h exp=%h", i, got_b, e); else n_pass++;
      if (b_pix) pix_cnt++;
      if (b_fs) begin
        if (fs_last >= 0) begin
          n_checks++;
          if (i - fs_last != 2 * B_HT * B_VT) $display("FAIL frame_period got=%0d exp=%0d", i - fs_last, 2 * B_HT * B_VT);
          else n_pass++;
        end
        fs_last = i;
        fs_cnt++;
      end
      if (b_vs == B_POL) begin
        vs_cnt++;
        if (b_hs == B_POL && hs_p != B_POL) hs_rise_in_vs++;
      end
      hs_p = b_hs;
    end
    n_checks++; if (fs_cnt != 3) $display("FAIL frame_b_count got=%0d exp=3", fs_cnt); else n_pass++;
    n_checks++; if (pix_cnt != 360) $display("FAIL pixtick_div2 got=%0d exp=360", pix_cnt); else n_pass++;
    n_checks++; if (vs_cnt != 180) $display("FAIL vsync_width_clk got=%0d exp=180", vs_cnt); else n_pass++;
    n_checks++; if (hs_rise_in_vs != 6) $display("FAIL hsync_in_vsync got=%0d exp=6", hs_rise_in_vs); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_freeze_and_reset();
    test_small_frame_div2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
